// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap sequencer and machine timer.
package trap_ctrl_pkg;

  // Raw exception causes reported by the committing instruction.
  typedef enum logic [3:0] {
    EXC_INSTR_MISALIGN = 4'd0,
    EXC_INSTR_FAULT    = 4'd1,
    EXC_ILLEGAL        = 4'd2,
    EXC_BREAKPOINT     = 4'd3,
    EXC_LOAD_MISALIGN  = 4'd4,
    EXC_LOAD_FAULT     = 4'd5,
    EXC_STORE_MISALIGN = 4'd6,
    EXC_STORE_FAULT    = 4'd7,
    EXC_ECALL          = 4'd8
  } exc_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAP  = 2'd1,
    ST_MRET  = 2'd2,
    ST_DRAIN = 2'd3
  } trap_state_t;

  localparam logic [31:0] IRQ_M_TIMER = 32'h8000_0007;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [1:0] TMR_MTIME_LO    = 2'd0;
  localparam logic [1:0] TMR_MTIME_HI    = 2'd1;
  localparam logic [1:0] TMR_MTIMECMP_LO = 2'd2;
  localparam logic [1:0] TMR_MTIMECMP_HI = 2'd3;

  // ECALL carries no privilege in its raw code; the mcause value depends on
  // the mode it was executed from (8 = U, 11 = M).
  function automatic logic [31:0] exc_cause(exc_code_t code, logic [1:0] priv);
    if (code == EXC_ECALL) begin
      return 32'd8 + {30'd0, priv};
    end
    return {28'd0, code};
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Word-addressed bus into the machine timer registers.
interface trap_ctrl_if;
  logic        tmr_req;
  logic        tmr_we;
  logic [1:0]  tmr_addr;
  logic [31:0] tmr_wdata;
  logic [31:0] tmr_rdata;
  logic        tmr_ack;

  modport master (
    output tmr_req, tmr_we, tmr_addr, tmr_wdata,
    input  tmr_rdata, tmr_ack
  );

  modport slave (
    input  tmr_req, tmr_we, tmr_addr, tmr_wdata,
    output tmr_rdata, tmr_ack
  );
endinterface

// File: rtl/trap_ctrl_mtimer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp, bus slave and mtip compare.
module trap_ctrl_mtimer
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_DIV    = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  trap_ctrl_if.slave  bus,
  output logic        mtip
);

  localparam int unsigned   PW      = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          tick;
  logic          wr;
  logic          rd;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    tick       = (pre_q == PRE_MAX);
    pre_d      = tick ? '0 : pre_q + 1'b1;
    wr         = bus.tmr_req & bus.tmr_we;
    rd         = bus.tmr_req & ~bus.tmr_we;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    rdata_d    = '0;
    ack_d      = bus.tmr_req;

    // A write to an mtime half overrides (and thereby drops) that cycle's increment.
    if (wr) begin
      case (bus.tmr_addr)
        TMR_MTIME_LO:    mtime_d    = {mtime_q[63:32], bus.tmr_wdata};
        TMR_MTIME_HI:    mtime_d    = {bus.tmr_wdata, mtime_q[31:0]};
        TMR_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus.tmr_wdata};
        TMR_MTIMECMP_HI: mtimecmp_d = {bus.tmr_wdata, mtimecmp_q[31:0]};
        default: ;
      endcase
    end

    if (rd) begin
      case (bus.tmr_addr)
        TMR_MTIME_LO:    rdata_d = mtime_q[31:0];
        TMR_MTIME_HI:    rdata_d = mtime_q[63:32];
        TMR_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        TMR_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      pre_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.tmr_rdata = rdata_q;
  assign bus.tmr_ack   = ack_q;
  assign mtip          = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, mret and the timer interrupt, pulses the
// CSR file, and redirects/flushes the pipeline; owns the machine timer.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_DIV    = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  exc_code_t   exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_val,
  input  logic        mret_req,
  input  logic        retire_valid,
  input  logic [31:0] retire_next_pc,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  input  logic        mtie,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv_mode,
  output logic        trap_enter,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_val,
  output logic        mret_exec,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  trap_ctrl_if.slave  tmr,
  output logic        mtip
);

  trap_state_t state_q, state_d;
  logic        trap_enter_q, trap_enter_d;
  logic        mret_exec_q, mret_exec_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] trap_cause_q, trap_cause_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] trap_val_q, trap_val_d;
  logic        irq;

  trap_ctrl_mtimer #(
    .TIMER_DIV    (TIMER_DIV),
    .MTIMECMP_RST (MTIMECMP_RST)
  ) u_mtimer (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tmr),
    .mtip  (mtip)
  );

  always_comb begin
    irq = mtip & mtie & ((priv_mode == PRIV_U) | mstatus_mie)
        & retire_valid & ~exc_valid & ~mret_req;

    state_d          = state_q;
    trap_enter_d     = 1'b0;
    mret_exec_d      = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    trap_cause_d     = '0;
    trap_pc_d        = '0;
    trap_val_d       = '0;

    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          state_d      = ST_TRAP;
          trap_cause_d = exc_cause(exc_code, priv_mode);
          trap_pc_d    = exc_pc;
          trap_val_d   = exc_val;
        end else if (mret_req && (priv_mode == PRIV_U)) begin
          // mret is privileged: from U-mode it becomes an illegal instruction trap.
          state_d      = ST_TRAP;
          trap_cause_d = {28'd0, EXC_ILLEGAL};
          trap_pc_d    = exc_pc;
        end else if (mret_req) begin
          state_d = ST_MRET;
        end else if (irq) begin
          state_d      = ST_TRAP;
          trap_cause_d = IRQ_M_TIMER;
          trap_pc_d    = retire_next_pc;
        end
      end
      ST_TRAP, ST_MRET: state_d = ST_DRAIN;
      default:          state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE && state_d == ST_TRAP) begin
      trap_enter_d     = 1'b1;
      flush_d          = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mtvec_in & 32'hFFFF_FFFC;
    end

    if (state_q == ST_IDLE && state_d == ST_MRET) begin
      mret_exec_d      = 1'b1;
      flush_d          = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_in;
    end

    // busy also covers the accepting cycle so commit holds the trapping instruction.
    busy = (state_q != ST_IDLE) | exc_valid | mret_req | irq;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      trap_enter_q     <= 1'b0;
      mret_exec_q      <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      trap_cause_q     <= '0;
      trap_pc_q        <= '0;
      trap_val_q       <= '0;
    end else begin
      state_q          <= state_d;
      trap_enter_q     <= trap_enter_d;
      mret_exec_q      <= mret_exec_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      trap_cause_q     <= trap_cause_d;
      trap_pc_q        <= trap_pc_d;
      trap_val_q       <= trap_val_d;
    end
  end

  assign trap_enter     = trap_enter_q;
  assign mret_exec      = mret_exec_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign trap_cause     = trap_cause_q;
  assign trap_pc        = trap_pc_q;
  assign trap_val       = trap_val_q;

endmodule
